// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: small TX FIFO feeding a start/data/parity/stop framer.
// Latency: a word pushed into an empty FIFO starts its frame two edges later.
// Backpressure: tx_ready drops when the FIFO is full; a push while full is dropped and flagged.

// Word FIFO between the bus push strobe and the framer.
// Latency: a pushed word is visible on pop_dat from the next cycle.
// Backpressure: full is taken from the registered count; a push while full is dropped and pulses overflow.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               pop_dat,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count + CNT_W'(do_push) - CNT_W'(do_pop);
            overflow <= push && full;
        end
    end
endmodule

module uart_tx_param #(
    parameter int CLKS_PER_BIT = 2604,
    parameter int DATA_LEN     = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          send_sig,
    input  logic [DATA_LEN-1:0]           data,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_overflow,
    output logic                          tx_data,
    output logic                          tx_busy,
    output logic                          tx_done
);
    // Any mode other than 1 or 2 sends no parity bit.
    localparam logic PAR_EN    = (PARITY == 1) || (PARITY == 2);
    localparam logic PAR_ODD   = (PARITY == 2);
    localparam int   STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
    localparam int   CNT_W     = $clog2(STOP_CLKS + 1);
    localparam int   BIT_W     = $clog2(DATA_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    clk_cnt;
    logic [CNT_W-1:0]    clk_cnt_nxt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [BIT_W-1:0]    bit_cnt_nxt;
    logic [DATA_LEN-1:0] shift_q;
    logic [DATA_LEN-1:0] shift_nxt;
    logic                par_bit;
    logic                par_nxt;
    logic                tx_data_nxt;
    logic                tx_busy_nxt;
    logic                tx_done_nxt;

    logic                fifo_pop;
    logic [DATA_LEN-1:0] fifo_rd_dat;
    logic                fifo_full;
    logic                fifo_empty;
    logic                bit_end;
    logic                stop_end;
    logic                last_bit;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_LEN)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (send_sig),
        .push_dat (data),
        .pop      (fifo_pop),
        .pop_dat  (fifo_rd_dat),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (tx_overflow)
    );

    assign tx_ready = !fifo_full;
    assign bit_end  = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign stop_end = (clk_cnt == CNT_W'(STOP_CLKS - 1));
    assign last_bit = (bit_cnt == BIT_W'(DATA_LEN - 1));

    // State, counters, shift register and the registered line outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift_q <= '0;
            par_bit <= 1'b0;
            tx_data <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            clk_cnt <= clk_cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            shift_q <= shift_nxt;
            par_bit <= par_nxt;
            tx_data <= tx_data_nxt;
            tx_busy <= tx_busy_nxt;
            tx_done <= tx_done_nxt;
        end
    end

    // Frame sequencing: each phase ends on its last clock of the bit period.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!fifo_empty) state_nxt = S_START;
            S_START:  if (bit_end) state_nxt = S_DATA;
            S_DATA:   if (bit_end && last_bit) state_nxt = PAR_EN ? S_PARITY : S_STOP;
            S_PARITY: if (bit_end) state_nxt = S_STOP;
            S_STOP:   if (stop_end) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Next values of the line, counters and shift register; the line only moves at bit boundaries.
    always_comb begin
        clk_cnt_nxt = clk_cnt + CNT_W'(1);
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_q;
        par_nxt     = par_bit;
        tx_data_nxt = tx_data;
        tx_busy_nxt = tx_busy;
        tx_done_nxt = 1'b0;
        fifo_pop    = 1'b0;
        case (state)
            S_IDLE: begin
                clk_cnt_nxt = '0;
                bit_cnt_nxt = '0;
                tx_data_nxt = 1'b1;
                tx_busy_nxt = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    shift_nxt   = fifo_rd_dat;
                    par_nxt     = (^fifo_rd_dat) ^ PAR_ODD;
                    tx_data_nxt = 1'b0;
                    tx_busy_nxt = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    clk_cnt_nxt = '0;
                    tx_data_nxt = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    clk_cnt_nxt = '0;
                    if (last_bit) begin
                        tx_data_nxt = PAR_EN ? par_bit : 1'b1;
                    end else begin
                        shift_nxt   = shift_q >> 1;
                        tx_data_nxt = shift_q[1];
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    clk_cnt_nxt = '0;
                    tx_data_nxt = 1'b1;
                end
            end
            S_STOP: begin
                if (stop_end) begin
                    clk_cnt_nxt = '0;
                    tx_busy_nxt = 1'b0;
                    tx_done_nxt = 1'b1;
                end
            end
            default: begin
                clk_cnt_nxt = '0;
                tx_data_nxt = 1'b1;
                tx_busy_nxt = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_param.sv
`timescale 1ns/1ps
module tb_uart_tx_param;
    // Four configurations: 8N1, 8E2, 8O2 (all 4 clocks/bit) and 5N1 at 2 clocks/bit.
    localparam int CPB_T [4] = '{4, 4, 4, 2};
    localparam int DL_T  [4] = '{8, 8, 8, 5};
    localparam int PAR_T [4] = '{0, 1, 2, 0};
    localparam int SB_T  [4] = '{1, 2, 2, 1};

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [3:0]      send = '0;
    logic [8:0]      din [4];
    wire  [3:0]      txd, busy, done, ovf, rdy;
    wire  [3:0][2:0] cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx_param #(
            .CLKS_PER_BIT (CPB_T[g]),
            .DATA_LEN     (DL_T[g]),
            .PARITY       (PAR_T[g]),
            .STOP_BITS    (SB_T[g]),
            .FIFO_DEPTH   (4)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .send_sig    (send[g]),
            .data        (din[g][DL_T[g]-1:0]),
            .tx_ready    (rdy[g]),
            .fifo_count  (cnt[g]),
            .tx_overflow (ovf[g]),
            .tx_data     (txd[g]),
            .tx_busy     (busy[g]),
            .tx_done     (done[g])
        );
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Called at a negedge; the word is pushed on the following posedge.
    task automatic push(input int i, input logic [8:0] d);
        send[i] = 1'b1;
        din[i]  = d;
        @(negedge clk);
        send[i] = 1'b0;
    endtask

    // Reference receiver: waits for a start bit, then checks every cycle of the
    // frame against a bit list built from the frame rules, then the done cycle.
    task automatic rx_check(input int i, input logic [8:0] d_in, input string nm, output int waited);
        logic       exp_q[$];
        logic [8:0] d;
        logic       pb;
        bit         found;
        d      = d_in & 9'((1 << DL_T[i]) - 1);
        waited = 0;
        found  = 0;
        for (int w = 0; w < 400 && !found; w++) begin
            @(negedge clk);
            if (txd[i] === 1'b0) begin
                found = 1;
            end else begin
                waited++;
                vectors++;
                if (busy[i] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s idle_busy: tx_busy=%b expected 0", nm, busy[i]);
                end
            end
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL %s start: no start bit seen, tx_data=%b expected 0", nm, txd[i]);
            return;
        end
        pb = 1'b0;
        for (int k = 0; k < CPB_T[i]; k++) exp_q.push_back(1'b0);
        for (int b = 0; b < DL_T[i]; b++) begin
            pb = pb ^ d[b];
            for (int k = 0; k < CPB_T[i]; k++) exp_q.push_back(d[b]);
        end
        if (PAR_T[i] == 1 || PAR_T[i] == 2) begin
            if (PAR_T[i] == 2) pb = ~pb;
            for (int k = 0; k < CPB_T[i]; k++) exp_q.push_back(pb);
        end
        for (int k = 0; k < SB_T[i] * CPB_T[i]; k++) exp_q.push_back(1'b1);
        for (int idx = 0; idx < exp_q.size(); idx++) begin
            if (idx > 0) @(negedge clk);
            vectors++;
            if (txd[i] !== exp_q[idx] || busy[i] !== 1'b1 || done[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL %s cyc%0d: data/busy/done=%b%b%b expected %b10",
                         nm, idx, txd[i], busy[i], done[i], exp_q[idx]);
            end
        end
        @(negedge clk);
        vectors++;
        if (txd[i] !== 1'b1 || busy[i] !== 1'b0 || done[i] !== 1'b1) begin
            miscompares++;
            $display("FAIL %s end: data/busy/done=%b%b%b expected 101", nm, txd[i], busy[i], done[i]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (txd[i] !== 1'b1 || busy[i] !== 1'b0 || done[i] !== 1'b0 || ovf[i] !== 1'b0
                || cnt[i] !== 3'd0 || rdy[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset%0d: data/busy/done/ovf/rdy=%b%b%b%b%b cnt=%0d expected 10001 cnt=0",
                         i, txd[i], busy[i], done[i], ovf[i], rdy[i], cnt[i]);
            end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_8n1();
        int w;
        push(0, 9'h0A5);
        rx_check(0, 9'h0A5, "basic_a5", w);
        @(negedge clk);
        vectors++;
        if (done[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_pulse: tx_done=%b expected 0", done[0]);
        end
    endtask

    task automatic test_parity();
        int w;
        push(1, 9'h007);
        rx_check(1, 9'h007, "even_07", w);
        push(2, 9'h007);
        rx_check(2, 9'h007, "odd_07", w);
    endtask

    task automatic test_fifo_overflow();
        int exp_cnt [6] = '{1, 1, 2, 3, 4, 4};
        int w;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    send[0] = 1'b1;
                    din[0]  = 9'(k + 1);
                    @(negedge clk);
                    vectors++;
                    if (cnt[0] !== 3'(exp_cnt[k]) || ovf[0] !== (k == 5) || rdy[0] !== (exp_cnt[k] != 4)) begin
                        miscompares++;
                        $display("FAIL fifo_push%0d: cnt=%0d ovf=%b rdy=%b expected cnt=%0d ovf=%b rdy=%b",
                                 k + 1, cnt[0], ovf[0], rdy[0], exp_cnt[k], k == 5, exp_cnt[k] != 4);
                    end
                end
                send[0] = 1'b0;
                @(negedge clk);
                vectors++;
                if (ovf[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL fifo_ovf_pulse: tx_overflow=%b expected 0", ovf[0]);
                end
            end
            begin
                for (int k = 1; k <= 5; k++) rx_check(0, 9'(k), "fifo_order", w);
            end
        join
        begin
            bit quiet = 1;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (txd[0] !== 1'b1 || busy[0] !== 1'b0) quiet = 0;
            end
            vectors++;
            if (!quiet || cnt[0] !== 3'd0) begin
                miscompares++;
                $display("FAIL fifo_no_sixth: quiet=%b cnt=%0d expected quiet=1 cnt=0", quiet, cnt[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int w1, w2;
        fork
            begin
                push(0, 9'h011);
                push(0, 9'h022);
            end
            begin
                rx_check(0, 9'h011, "b2b_11", w1);
                rx_check(0, 9'h022, "b2b_22", w2);
            end
        join
        vectors++;
        if (w2 !== 0) begin
            miscompares++;
            $display("FAIL b2b_gap: idle cycles=%0d expected 1", w2 + 1);
        end
    endtask

    task automatic test_reset_abort();
        fork
            begin
                push(0, 9'h0C3);
                push(0, 9'h05A);
                push(0, 9'h03C);
            end
            begin
                bit found = 0;
                for (int w = 0; w < 50 && !found; w++) begin
                    @(negedge clk);
                    if (txd[0] === 1'b0) found = 1;
                end
                repeat (17) @(negedge clk);
                vectors++;
                if (!found || cnt[0] !== 3'd2) begin
                    miscompares++;
                    $display("FAIL abort_pre: started=%b cnt=%0d expected started=1 cnt=2", found, cnt[0]);
                end
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                vectors++;
                if (txd[0] !== 1'b1 || busy[0] !== 1'b0 || cnt[0] !== 3'd0 || done[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL abort_post: data/busy/done=%b%b%b cnt=%0d expected 100 cnt=0",
                             txd[0], busy[0], done[0], cnt[0]);
                end
            end
        join
        begin
            bit quiet = 1;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (txd[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) quiet = 0;
            end
            vectors++;
            if (!quiet) begin
                miscompares++;
                $display("FAIL abort_quiet: line activity after reset, quiet=%b expected 1", quiet);
            end
        end
    endtask

    task automatic test_short_5n1();
        int w;
        push(3, 9'h01F);
        rx_check(3, 9'h01F, "short_1f", w);
    endtask

    task automatic test_random();
        int w;
        for (int r = 0; r < 12; r++) begin
            int         i;
            int         n;
            logic [8:0] q[$];
            i = $urandom_range(0, 3);
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) q.push_back(9'($urandom));
            fork
                begin
                    for (int k = 0; k < n; k++) push(i, q[k]);
                end
                begin
                    for (int k = 0; k < n; k++) rx_check(i, q[k], "random", w);
                end
            join
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) din[i] = '0;
        test_reset();
        test_basic_8n1();
        test_parity();
        test_fifo_overflow();
        test_back_to_back();
        test_reset_abort();
        test_short_5n1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
